// File: rtl/video_mem_wr_addr_seq.sv
// ---------------------------------------------------------------------------
// video_mem_wr_addr_seq
//
// Write-address sequencer for the video memory port. It sits between the
// CPU-side register decoder and the video memory write port. The CPU programs
// a start address, a stride, an optional row length and a row pitch through a
// byte-wide configuration bus. Each 'inc' strobe then advances the address,
// so blitter-style sprite and text writes need no per-pixel address reload.
//
// Walk modes:
//   ROW_LEN == 0 : linear walk, addr += STRIDE on every inc
//   ROW_LEN != 0 : rectangular walk, ROW_LEN addresses per row spaced by
//                  STRIDE. The next row starts at row_start + PITCH.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   rst            asynchronous active-high reset
//   g_en           global enable; when low only row_done may change (clears)
//   d_in           configuration data byte (DATA_W bits)
//   cfg_we         configuration write strobe
//   cfg_sel        register select: 0=ADDR, 1=STRIDE, 2=ROW_LEN, 3=PITCH
//   cfg_lane       byte lane of the selected register to write
//   inc            advance strobe, one per video memory write
//   video_mem_addr current write address (registered)
//   row_done       one-cycle pulse after the inc that completes a row
//   ovf            sticky flag, set when address arithmetic wraps past 2**ADDR_W
//
// Parameter constraint: ceil(ADDR_W/DATA_W) must not exceed 2**LANE_W.
// ---------------------------------------------------------------------------
module video_mem_wr_addr_seq #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int LANE_W = 1,
    parameter int COL_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              g_en,
    input  logic [DATA_W-1:0] d_in,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [LANE_W-1:0] cfg_lane,
    input  logic              inc,
    output logic [ADDR_W-1:0] video_mem_addr,
    output logic              row_done,
    output logic              ovf
);

    // Number of byte lanes needed to cover one address-wide register.
    localparam int NLANE = (ADDR_W + DATA_W - 1) / DATA_W;

    // Register select codes on cfg_sel.
    typedef enum logic [1:0] {
        SEL_ADDR    = 2'd0,
        SEL_STRIDE  = 2'd1,
        SEL_ROW_LEN = 2'd2,
        SEL_PITCH   = 2'd3
    } cfg_sel_t;

    // Programmable registers and walk state.
    logic [ADDR_W-1:0] stride;
    logic [COL_W-1:0]  row_len;
    logic [ADDR_W-1:0] pitch;
    logic [ADDR_W-1:0] row_start;
    logic [COL_W-1:0]  col;

    // Decoded control.
    cfg_sel_t          sel;
    logic              cfg_write;
    logic              addr_write;
    logic              advance;
    logic              rect_mode;
    logic              row_wrap;

    // Candidate next values, one bit wider to expose the carry out.
    logic [ADDR_W:0]   step_sum;
    logic [ADDR_W:0]   pitch_sum;

    // Lane-merged versions of every register, used only when written.
    logic [ADDR_W-1:0] addr_merged;
    logic [ADDR_W-1:0] row_start_merged;
    logic [ADDR_W-1:0] stride_merged;
    logic [ADDR_W-1:0] pitch_merged;
    logic [COL_W-1:0]  row_len_merged;

    // Replace one DATA_W-wide lane of an address-wide register with data.
    // Bits of the lane above the register width simply have no destination,
    // and a lane outside the lane range leaves the register untouched.
    function automatic logic [ADDR_W-1:0] merge_lane_addr(
        input logic [ADDR_W-1:0] old_val,
        input logic [DATA_W-1:0] data,
        input logic [LANE_W-1:0] lane
    );
        logic [ADDR_W-1:0] result;
        result = old_val;
        for (int i = 0; i < ADDR_W; i++) begin
            if ((int'(lane) < NLANE) && ((i / DATA_W) == int'(lane))) begin
                result[i] = data[i % DATA_W];
            end
        end
        return result;
    endfunction

    // Same lane merge for the COL_W-wide row-length register. A lane lying
    // entirely above COL_W matches no bit and so the write is ignored.
    function automatic logic [COL_W-1:0] merge_lane_col(
        input logic [COL_W-1:0]  old_val,
        input logic [DATA_W-1:0] data,
        input logic [LANE_W-1:0] lane
    );
        logic [COL_W-1:0] result;
        result = old_val;
        for (int i = 0; i < COL_W; i++) begin
            if ((int'(lane) < NLANE) && ((i / DATA_W) == int'(lane))) begin
                result[i] = data[i % DATA_W];
            end
        end
        return result;
    endfunction

    // Control decode. An ADDR write in the same cycle as inc takes priority
    // and the inc is dropped, so the freshly loaded address is not skipped.
    always_comb begin
        sel        = cfg_sel_t'(cfg_sel);
        cfg_write  = g_en & cfg_we;
        addr_write = cfg_write && (sel == SEL_ADDR);
        advance    = g_en & inc & ~addr_write;
        rect_mode  = (row_len != '0);
        // Using >= rather than == means a ROW_LEN shrunk mid-row below the
        // current column still ends the row on the next inc instead of
        // running on until the column counter wraps.
        row_wrap   = rect_mode && (col >= (row_len - COL_W'(1)));
    end

    // Adders for the two address sources. Both read the pre-write register
    // values, so a STRIDE/PITCH/ROW_LEN write alongside inc affects only the
    // following inc.
    always_comb begin
        step_sum  = {1'b0, video_mem_addr} + {1'b0, stride};
        pitch_sum = {1'b0, row_start} + {1'b0, pitch};
    end

    // Lane merges for the configuration write path.
    always_comb begin
        addr_merged      = merge_lane_addr(video_mem_addr, d_in, cfg_lane);
        row_start_merged = merge_lane_addr(row_start, d_in, cfg_lane);
        stride_merged    = merge_lane_addr(stride, d_in, cfg_lane);
        pitch_merged     = merge_lane_addr(pitch, d_in, cfg_lane);
        row_len_merged   = merge_lane_col(row_len, d_in, cfg_lane);
    end

    // Main state register. row_done is a pulse and clears on every clock,
    // regardless of g_en. The config-write and advance paths never target
    // the same register in one cycle: advance is suppressed on ADDR writes
    // and the other config registers are never touched by advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            video_mem_addr <= '0;
            row_start      <= '0;
            col            <= '0;
            stride         <= ADDR_W'(1);
            row_len        <= '0;
            pitch          <= '0;
            row_done       <= 1'b0;
            ovf            <= 1'b0;
        end else begin
            row_done <= 1'b0;

            if (cfg_write) begin
                case (sel)
                    SEL_ADDR: begin
                        // Loading a new start point begins a fresh row and a
                        // fresh overflow history.
                        video_mem_addr <= addr_merged;
                        row_start      <= row_start_merged;
                        col            <= '0;
                        ovf            <= 1'b0;
                    end
                    SEL_STRIDE:  stride  <= stride_merged;
                    SEL_ROW_LEN: row_len <= row_len_merged;
                    SEL_PITCH:   pitch   <= pitch_merged;
                    default: ;
                endcase
            end

            if (advance) begin
                if (row_wrap) begin
                    // End of row: jump to the start of the next row.
                    row_start      <= pitch_sum[ADDR_W-1:0];
                    video_mem_addr <= pitch_sum[ADDR_W-1:0];
                    col            <= '0;
                    row_done       <= 1'b1;
                    if (pitch_sum[ADDR_W]) begin
                        ovf <= 1'b1;
                    end
                end else begin
                    // Linear walk or a step within the current row.
                    video_mem_addr <= step_sum[ADDR_W-1:0];
                    if (rect_mode) begin
                        col <= col + COL_W'(1);
                    end
                    if (step_sum[ADDR_W]) begin
                        ovf <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_video_mem_wr_addr_seq.sv
// ---------------------------------------------------------------------------
// tb_video_mem_wr_addr_seq
//
// Self-checking bench for video_mem_wr_addr_seq with default parameters
// (8-bit data bus, 16-bit address, two lanes, 8-bit column).
// A table of directed vectors covers lane loading, linear and rectangular
// walks, overflow, simultaneous write/inc and mid-row ROW_LEN changes.
// Hand-written sequences cover the g_en hold behaviour and an asynchronous
// reset in the middle of a row.
// ---------------------------------------------------------------------------
module tb_video_mem_wr_addr_seq;

    localparam logic [1:0] ADR = 2'd0;
    localparam logic [1:0] STR = 2'd1;
    localparam logic [1:0] RLN = 2'd2;
    localparam logic [1:0] PIT = 2'd3;

    logic        clk;
    logic        rst;
    logic        g_en;
    logic [7:0]  d_in;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [0:0]  cfg_lane;
    logic        inc;
    logic [15:0] video_mem_addr;
    logic        row_done;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic        lane;
        logic [7:0]  d;
        logic        inc;
        logic [15:0] exp_addr;
        logic        exp_rd;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    video_mem_wr_addr_seq #(
        .DATA_W(8),
        .ADDR_W(16),
        .LANE_W(1),
        .COL_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .g_en(g_en),
        .d_in(d_in),
        .cfg_we(cfg_we),
        .cfg_sel(cfg_sel),
        .cfg_lane(cfg_lane),
        .inc(inc),
        .video_mem_addr(video_mem_addr),
        .row_done(row_done),
        .ovf(ovf)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic we, input logic [1:0] sel, input logic lane,
                          input logic [7:0] d, input logic inc_v,
                          input logic [15:0] ea, input logic er, input logic eo);
        vec_t v;
        v.we = we; v.sel = sel; v.lane = lane; v.d = d; v.inc = inc_v;
        v.exp_addr = ea; v.exp_rd = er; v.exp_ovf = eo;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, let the rising edge take them, then settle.
    task automatic applyStimulus(input logic ge, input logic we, input logic [1:0] sel,
                                 input logic lane, input logic [7:0] d, input logic inc_v);
        g_en     = ge;
        cfg_we   = we;
        cfg_sel  = sel;
        cfg_lane = lane;
        d_in     = d;
        inc      = inc_v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] ea,
                               input logic er, input logic eo);
        checks++;
        if (video_mem_addr !== ea || row_done !== er || ovf !== eo) begin
            errors++;
            $display("[TB] FAIL %s: got addr=%h row_done=%b ovf=%b, expected addr=%h row_done=%b ovf=%b",
                     tag, video_mem_addr, row_done, ovf, ea, er, eo);
        end
    endtask

    initial begin
        // Directed vector table: we, sel, lane, d, inc, exp addr, row_done, ovf
        addVec(1, ADR, 0, 8'h34, 0, 16'h0034, 0, 0);
        addVec(1, ADR, 1, 8'h12, 0, 16'h1234, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1235, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1236, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1237, 0, 0);
        addVec(1, STR, 0, 8'h04, 0, 16'h1237, 0, 0);
        addVec(1, ADR, 1, 8'hFF, 0, 16'hFF37, 0, 0);
        addVec(1, ADR, 0, 8'hFC, 0, 16'hFFFC, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h0000, 0, 1);
        addVec(0, ADR, 0, 8'h00, 1, 16'h0004, 0, 1);
        addVec(0, ADR, 0, 8'h00, 1, 16'h0008, 0, 1);
        addVec(1, ADR, 0, 8'h00, 0, 16'h0000, 0, 0);
        addVec(1, STR, 0, 8'h01, 0, 16'h0000, 0, 0);
        addVec(1, RLN, 0, 8'h03, 0, 16'h0000, 0, 0);
        addVec(1, PIT, 0, 8'h40, 0, 16'h0000, 0, 0);
        addVec(1, PIT, 1, 8'h01, 0, 16'h0000, 0, 0);
        addVec(1, ADR, 1, 8'h10, 0, 16'h1000, 0, 0);
        addVec(1, ADR, 0, 8'h00, 0, 16'h1000, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1001, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1002, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1140, 1, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1141, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1142, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1280, 1, 0);
        addVec(0, ADR, 0, 8'h00, 0, 16'h1280, 0, 0);
        // STRIDE write with inc: this inc still uses stride 1
        addVec(1, STR, 0, 8'h02, 1, 16'h1281, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1283, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h13C0, 1, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h13C2, 0, 0);
        // ROW_LEN shrunk mid-row (col=1 >= 0): next inc wraps
        addVec(1, RLN, 0, 8'h01, 0, 16'h13C2, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1500, 1, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1640, 1, 0);
        // ROW_LEN lane 1 lies above COL_W: ignored
        addVec(1, RLN, 1, 8'hFF, 0, 16'h1640, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1780, 1, 0);
        addVec(1, RLN, 0, 8'h00, 0, 16'h1780, 0, 0);
        addVec(0, ADR, 0, 8'h00, 1, 16'h1782, 0, 0);
        // ADDR lane0 write with inc: write wins, no increment
        addVec(1, ADR, 0, 8'h55, 1, 16'h1755, 0, 0);
        addVec(0, ADR, 0, 8'h00, 0, 16'h1755, 0, 0);
        // PITCH write with inc: linear step uses stride 2
        addVec(1, PIT, 0, 8'h80, 1, 16'h1757, 0, 0);
        addVec(1, RLN, 0, 8'h01, 0, 16'h1757, 0, 0);
        // row_start is 0x1755 after the lane0 load, pitch now 0x0180
        addVec(0, ADR, 0, 8'h00, 1, 16'h18D5, 1, 0);

        g_en = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_lane = 1'b0;
        d_in = 8'h00; inc = 1'b0;
        rst = 1'b1;
        #2;
        checkOutput("reset_state", 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(1'b1, vecs[i].we, vecs[i].sel, vecs[i].lane, vecs[i].d, vecs[i].inc);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_rd, vecs[i].exp_ovf);
        end

        // g_en low holds everything while a pending row_done clears.
        applyStimulus(1'b1, 1'b1, ADR, 1'b1, 8'h20, 1'b0);
        checkOutput("gen_setup_hi", 16'h20D5, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, ADR, 1'b0, 8'h00, 1'b0);
        checkOutput("gen_setup_lo", 16'h2000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, PIT, 1'b0, 8'h40, 1'b0);
        applyStimulus(1'b1, 1'b1, PIT, 1'b1, 8'h01, 1'b0);
        applyStimulus(1'b1, 1'b0, ADR, 1'b0, 8'h00, 1'b1);
        checkOutput("gen_wrap", 16'h2140, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, ADR, i[0], 8'hAA, 1'b1);
            checkOutput($sformatf("gen_off%0d", i), 16'h2140, 1'b0, 1'b0);
        end
        // ROW_LEN is still 1, so re-enabled inc wraps again.
        applyStimulus(1'b1, 1'b0, ADR, 1'b0, 8'h00, 1'b1);
        checkOutput("gen_back_on", 16'h2280, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a row.
        applyStimulus(1'b1, 1'b1, RLN, 1'b0, 8'h03, 1'b0);
        applyStimulus(1'b1, 1'b1, STR, 1'b0, 8'h01, 1'b0);
        applyStimulus(1'b1, 1'b1, ADR, 1'b1, 8'h10, 1'b0);
        applyStimulus(1'b1, 1'b1, ADR, 1'b0, 8'h00, 1'b0);
        checkOutput("rst_setup", 16'h1000, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, ADR, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 1'b0, ADR, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 1'b0, ADR, 1'b0, 8'h00, 1'b1);
        checkOutput("rst_row_end", 16'h1140, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, ADR, 1'b0, 8'h00, 1'b1);
        checkOutput("rst_mid_row", 16'h1141, 1'b0, 1'b0);
        g_en = 1'b0; inc = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async", 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, ADR, 1'b0, 8'h00, 1'b1);
        checkOutput("post_rst_inc1", 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, ADR, 1'b0, 8'h00, 1'b1);
        checkOutput("post_rst_inc2", 16'h0002, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, ADR, 1'b0, 8'h00, 1'b1);
        checkOutput("post_rst_inc3", 16'h0003, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_mem_wr_addr_seq.md
Name: video_mem_wr_addr_seq

Overview:
Parametrised next-generation write-address sequencer for the video memory port.
- Loads the start address byte-lane by byte-lane from the 8-bit data bus, as the current generator does.
- Adds a programmable stride, an optional rectangular (row/pitch) walk, a row-done pulse and a sticky overflow flag.
- Sits between the CPU-side register decoder and the video memory write port. Blitter-style sprite and text writes need no per-pixel address reload.

Parameters:
DATA_W, 8, width of the configuration data bus d_in
ADDR_W, 16, width of the video memory address
LANE_W, 1, width of the lane selector; NLANE = ceil(ADDR_W/DATA_W) must be <= 2**LANE_W
COL_W, 8, width of the row-length register and the column counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
g_en  input  1  global enable; when low, no state changes except rst and the row_done clear
d_in  input  DATA_W  configuration data byte
cfg_we  input  1  configuration write strobe
cfg_sel  input  2  register select: 0=ADDR, 1=STRIDE, 2=ROW_LEN, 3=PITCH
cfg_lane  input  LANE_W  byte lane: 0 = bits [DATA_W-1:0], 1 = next DATA_W bits, and so on
inc  input  1  advance strobe, one per video memory write
video_mem_addr  output  ADDR_W  current write address (registered)
row_done  output  1  one-cycle pulse after the inc that completes a row
ovf  output  1  sticky flag: address arithmetic wrapped past 2**ADDR_W

Behaviour:
- Reset (async, rst=1):
  - video_mem_addr=0, row_start=0, col=0.
  - STRIDE=1, ROW_LEN=0, PITCH=0.
  - row_done=0, ovf=0.
- Internal registers:
  - STRIDE, ADDR_W bits.
  - ROW_LEN, COL_W bits.
  - PITCH, ADDR_W bits.
  - row_start, ADDR_W bits.
  - col, COL_W bits.
- Config write (g_en & cfg_we): writes d_in into lane cfg_lane of the selected register.
  - Bits of a lane beyond the register width are dropped.
  - cfg_lane >= NLANE, or a lane entirely above a register's width: write ignored.
  - ADDR write: updates video_mem_addr and the same lane of row_start, clears col to 0, clears ovf.
  - Other lanes keep their values, so a 16-bit address is set with two writes in either order.
- Advance (g_en & inc & no ADDR write this cycle):
  - Linear mode (ROW_LEN==0): video_mem_addr <= video_mem_addr + STRIDE, modulo 2**ADDR_W.
  - Rect mode, col != ROW_LEN-1: video_mem_addr += STRIDE; col += 1.
  - Rect mode, col == ROW_LEN-1:
    - row_start <= row_start + PITCH.
    - video_mem_addr <= row_start + PITCH (old row_start).
    - col <= 0.
    - row_done=1 in the next cycle.
  - ovf is set on any carry out of bit ADDR_W-1 in the sum that produced the new address.
- Simultaneous events:
  - cfg_we to ADDR together with inc: the write wins and inc is dropped.
  - cfg_we to STRIDE, ROW_LEN or PITCH together with inc: inc uses the pre-write values; the write takes effect for the next inc.
- ROW_LEN changed mid-row: col is not cleared.
  - If col >= new ROW_LEN-1, the next inc takes the row-wrap path.
  - Comparison is col >= ROW_LEN-1 when ROW_LEN != 0.
- row_done:
  - High for exactly one cycle after a row-wrap inc, otherwise 0.
  - Cleared on the next clock even if g_en=0.
- Latency: one clock from inc or cfg_we to the updated video_mem_addr. No combinational path from inputs to outputs.
- g_en=0: inc and cfg_we are ignored. All registers hold, except that row_done clears.
- rst asserted mid-row or mid-sequence: immediate return to reset values. No partial lane state survives.

Test Plan:
- Reset, then two writes: lane0=0x34, lane1=0x12 to ADDR -> video_mem_addr=0x1234, ovf=0; three inc -> 0x1235, 0x1236, 0x1237.
- STRIDE=4, ADDR=0xFFFC, one inc -> video_mem_addr=0x0000, ovf=1. ovf stays 1 across further incs; an ADDR lane0 write clears it.
- ROW_LEN=3, PITCH=0x0140, STRIDE=1, ADDR=0x1000; six incs -> 0x1001, 0x1002, 0x1140, 0x1141, 0x1142, 0x1280. row_done pulses the cycle after the 3rd and 6th inc only.
- ADDR lane0 write of 0x55 together with inc, starting from 0x1234 -> 0x1255, col=0, no increment.
- g_en=0 while driving inc and cfg_we for 5 cycles -> all outputs unchanged; a pending row_done still clears after one cycle.
- Assert rst asynchronously mid-row (col=1, addr=0x1141) -> outputs go to 0 without waiting for clk; after release STRIDE=1, and linear incs give 0x0001.
